// File: rtl/mpadd_pkg.sv
// Shared types and sizing helpers for the multi-precision add/sub engine.
// Optional feature macro: MPADD_CARRY_SELECT_EN (two limbs per RUN cycle).
package mpadd_pkg;

    localparam int unsigned MPADD_LIMB_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mpadd_state_t;

    // Limbs needed to hold a (width+1)-bit result; optionally rounded up to even.
    function automatic int unsigned mpadd_nlimb(input int unsigned width,
                                                input int unsigned limb_w,
                                                input bit          even);
        int unsigned n;
        n = (width + 1 + limb_w - 1) / limb_w;
        if (even && n[0]) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/mpadd_limb.sv
// Combinational LIMB_W-bit adder slice with carry in/out.
module mpadd_limb
    import mpadd_pkg::*;
#(
    parameter int unsigned LIMB_W = MPADD_LIMB_W
) (
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    input  logic              cin,
    output logic [LIMB_W-1:0] sum,
    output logic              cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{LIMB_W{1'b0}}, cin};

endmodule

// File: rtl/mp_addsub_seq.sv
// Sequential multi-precision adder/subtractor: one limb (or two limbs with
// carry select) per cycle through a registered carry, start/busy/done handshake.
// Optional feature macro: MPADD_CARRY_SELECT_EN.
module mp_addsub_seq
    import mpadd_pkg::*;
#(
    parameter int unsigned WIDTH  = 1027,
    parameter int unsigned LIMB_W = MPADD_LIMB_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
);

`ifdef MPADD_CARRY_SELECT_EN
    localparam bit CSEL = 1'b1;
`else
    localparam bit CSEL = 1'b0;
`endif

    localparam int unsigned NLIMB  = mpadd_nlimb(WIDTH, LIMB_W, CSEL);
    localparam int unsigned P      = NLIMB * LIMB_W;
    localparam int unsigned LPS    = CSEL ? 2 : 1;
    localparam int unsigned STEP_W = LPS * LIMB_W;
    localparam int unsigned NSTEP  = NLIMB / LPS;
    localparam int unsigned IDXW   = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSTEP - 1);

    mpadd_state_t      state_q;
    logic [IDXW-1:0]   idx_q;
    logic              busy_q;
    logic              done_q;
    logic              carry_q;
    logic [P-1:0]      a_q;
    logic [P-1:0]      b_q;
    logic [P-1:0]      res_q;
    logic [STEP_W-1:0] step_sum_d;
    logic              step_cout_d;

`ifdef MPADD_CARRY_SELECT_EN
    logic [LIMB_W-1:0] lo_sum;
    logic [LIMB_W-1:0] hi_sum0;
    logic [LIMB_W-1:0] hi_sum1;
    logic              lo_cout;
    logic              hi_cout0;
    logic              hi_cout1;

    mpadd_limb #(.LIMB_W(LIMB_W)) u_limb_lo (
        .a   (a_q[LIMB_W-1:0]),
        .b   (b_q[LIMB_W-1:0]),
        .cin (carry_q),
        .sum (lo_sum),
        .cout(lo_cout)
    );

    mpadd_limb #(.LIMB_W(LIMB_W)) u_limb_hi0 (
        .a   (a_q[2*LIMB_W-1:LIMB_W]),
        .b   (b_q[2*LIMB_W-1:LIMB_W]),
        .cin (1'b0),
        .sum (hi_sum0),
        .cout(hi_cout0)
    );

    mpadd_limb #(.LIMB_W(LIMB_W)) u_limb_hi1 (
        .a   (a_q[2*LIMB_W-1:LIMB_W]),
        .b   (b_q[2*LIMB_W-1:LIMB_W]),
        .cin (1'b1),
        .sum (hi_sum1),
        .cout(hi_cout1)
    );

    // Pick the upper limb's speculative result using the lower limb's carry-out.
    always_comb begin
        step_sum_d  = {(lo_cout ? hi_sum1 : hi_sum0), lo_sum};
        step_cout_d = lo_cout ? hi_cout1 : hi_cout0;
    end
`else
    mpadd_limb #(.LIMB_W(LIMB_W)) u_limb (
        .a   (a_q[LIMB_W-1:0]),
        .b   (b_q[LIMB_W-1:0]),
        .cin (carry_q),
        .sum (step_sum_d),
        .cout(step_cout_d)
    );
`endif

    // Handshake FSM with registered busy/done and step counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        idx_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Operand/result datapath. Operands shift right one step per RUN cycle so the
    // active limb is always at the bottom; B is inverted at latch time for subtract,
    // and results shift in from the top so limb 0 lands at bit 0 after the last step.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
        end else if (state_q == IDLE && start) begin
            a_q     <= P'(in_a);
            b_q     <= subtract ? ~P'(in_b) : P'(in_b);
            carry_q <= subtract;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> STEP_W;
            b_q     <= b_q >> STEP_W;
            carry_q <= step_cout_d;
            res_q   <= P'({step_sum_d, res_q} >> STEP_W);
        end
    end

    if (P > WIDTH + 1) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^res_q[P-1:WIDTH+1];
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q[WIDTH:0];

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Scoreboard bench for mp_addsub_seq: driver models acceptance and pushes expected
// results with their due cycle; a negedge monitor checks busy/done/result.
module tb_mp_addsub_seq;

    parameter int unsigned WIDTH  = 1027;
    parameter int unsigned LIMB_W = 128;

    localparam int unsigned NL_RAW = (WIDTH + LIMB_W) / LIMB_W;
`ifdef MPADD_CARRY_SELECT_EN
    localparam int unsigned NL  = NL_RAW + (NL_RAW % 2);
    localparam int unsigned LAT = NL / 2;
`else
    localparam int unsigned NL  = NL_RAW;
    localparam int unsigned LAT = NL;
`endif

    typedef logic [WIDTH:0]   res_t;
    typedef logic [WIDTH-1:0] op_t;
    typedef struct {
        res_t        res;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start = 1'b0;
    logic subtract = 1'b0;
    op_t  in_a = '0;
    op_t  in_b = '0;
    logic busy;
    logic done;
    res_t result;

    mp_addsub_seq #(.WIDTH(WIDTH), .LIMB_W(LIMB_W)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .subtract(subtract),
        .in_a    (in_a),
        .in_b    (in_b),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        exp_q[$];
    int unsigned n_vec    = 0;
    int unsigned n_err    = 0;
    int unsigned bf       = 1;
    int unsigned bt       = 0;
    int unsigned next_acc = 0;
    int unsigned mon_from = 32'hFFFF_FFFF;
    res_t        last_res = '0;

    function automatic void chk(input string name, input res_t act, input res_t exp);
        logic [127:0] la;
        logic [127:0] le;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            la = 128'(act);
            le = 128'(exp);
            $display("FAIL %s at cycle %0d: got msb=%b low=%h, want msb=%b low=%h",
                     name, cyc, act[WIDTH], la, exp[WIDTH], le);
        end
    endfunction

    // Reference: (A op B) mod 2^(WIDTH+1).
    function automatic res_t model(input op_t a, input op_t b, input logic sub);
        res_t ea;
        res_t eb;
        ea = res_t'(a);
        eb = res_t'(b);
        return sub ? (ea - eb) : (ea + eb);
    endfunction

    function automatic op_t rnd_op();
        logic [WIDTH+31:0] t;
        t = '0;
        for (int i = 0; i < int'(WIDTH); i += 32) t[i +: 32] = $urandom();
        case ($urandom_range(0, 7))
            0: return '1;
            1: return '0;
            2: return op_t'($urandom_range(0, 15));
            default: return t[WIDTH-1:0];
        endcase
    endfunction

    // One driven cycle, entered and left at a falling edge.
    task automatic tick(input logic s, input logic sub, input op_t a, input op_t b, input logic rst);
        int unsigned c;
        c        = cyc;
        resetn   = ~rst;
        start    = s;
        subtract = sub;
        in_a     = a;
        in_b     = b;
        if (rst) begin
            if (bt > c) bt = c;
            exp_q.delete();
            last_res = '0;
            next_acc = c + 2;
            if (mon_from == 32'hFFFF_FFFF) mon_from = c + 1;
        end else if (s && (c + 1 >= next_acc)) begin
            exp_q.push_back('{res: model(a, b, sub), due: c + 1 + LAT});
            bf       = c + 1;
            bt       = c + 1 + LAT;
            next_acc = c + 1 + LAT + 2;
        end
        @(negedge clk);
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 1'b0);
    endtask

    task automatic issue(input op_t a, input op_t b, input logic sub);
        while (cyc + 1 < next_acc) idle_tick();
        tick(1'b1, sub, a, b, 1'b0);
    endtask

    // Monitor: busy window, done timing/value, result stability while idle.
    always @(negedge clk) begin
        if (cyc >= mon_from) begin
            chk("busy", res_t'(busy), res_t'((cyc >= bf) && (cyc <= bt)));
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                chk("done_missing", res_t'(done), res_t'(1'b1));
                void'(exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", res_t'(done), res_t'(1'b0));
                end else begin
                    chk("done_latency", res_t'(cyc), res_t'(exp_q[0].due));
                    chk("result", result, exp_q[0].res);
                    last_res = exp_q[0].res;
                    void'(exp_q.pop_front());
                end
            end else if (!((cyc >= bf) && (cyc <= bt))) begin
                chk("result_hold", result, last_res);
            end
        end
    end

    initial begin
        op_t ones;
        ones = '1;
        @(negedge clk);
        repeat (3) tick(1'b0, 1'b0, '0, '0, 1'b1);

        // Directed: 1+1, all-ones add, borrow, zero subtract.
        issue(op_t'(1), op_t'(1), 1'b0);
        issue(ones, ones, 1'b0);
        issue(op_t'(5), op_t'(7), 1'b1);
        issue('0, '0, 1'b1);
        issue(ones, '0, 1'b1);
        issue('0, op_t'(1), 1'b1);

        // start held high with changing inputs.
        while (cyc + 1 < next_acc) idle_tick();
        repeat (30) tick(1'b1, 1'($urandom_range(0, 1)), rnd_op(), rnd_op(), 1'b0);

        // Reset during RUN cycle 4, then a normal op.
        issue(ones, op_t'(3), 1'b0);
        repeat (3) idle_tick();
        tick(1'b0, 1'b0, '0, '0, 1'b1);
        issue(op_t'(3), op_t'(4), 1'b0);

        // Random ops with random gaps.
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) idle_tick();
            issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end

        repeat (LAT + 5) idle_tick();
        chk("drain", res_t'(exp_q.size()), res_t'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
